// File: rtl/region_decoder_pkg.sv
// region_decoder_pkg: shared types and the address-range test for the region decoder
package region_decoder_pkg;
    localparam int ADDR_MAX_W = 32;
    typedef logic [3:0] region_idx_t;
    typedef struct packed {
        logic        valid;
        region_idx_t idx;
        logic        unmapped;
    } read_tag_t;
    function automatic logic region_hit(
        input logic [ADDR_MAX_W-1:0] addr,
        input logic [ADDR_MAX_W-1:0] base,
        input logic [ADDR_MAX_W-1:0] limit
    );
        return (addr >= base) && (addr <= limit);
    endfunction
endpackage

// File: rtl/region_decoder_pipelined_read_tag_pipe.sv
// read_tag_pipe: fixed-depth shift register carrying read tags to the return stage
module read_tag_pipe
    import region_decoder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  read_tag_t tag_in,
    output read_tag_t tag_out
);
    read_tag_t [DEPTH-1:0] pipe_q, pipe_d;
    always_comb begin
        pipe_d = pipe_q;
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pipe_q <= '0;
        else pipe_q <= pipe_d;
    assign tag_out = pipe_q[DEPTH-1];
endmodule

// File: rtl/region_decoder_pipelined.sv
// region_decoder_pipelined: Avalon-MM region decoder with registered fan-out, fixed-latency read-back and error capture
module region_decoder_pipelined
    import region_decoder_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int NUM_REGIONS = 5,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {12'hE00, 12'hC00, 12'h800, 12'h400, 12'h000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {12'hFFF, 12'hDFF, 12'hBFF, 12'h7FF, 12'h3FF},
    parameter int RD_LATENCY = 1,
    parameter int MAX_PENDING = 4,
    parameter logic [DATA_W-1:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ADDR_W-1:0]             avs_address,
    input  logic                          avs_chipselect,
    input  logic                          avs_read,
    input  logic                          avs_write,
    input  logic [DATA_W-1:0]             avs_writedata,
    output logic [DATA_W-1:0]             avs_readdata,
    output logic                          avs_readdatavalid,
    output logic                          avs_waitrequest,
    output logic [NUM_REGIONS-1:0]        reg_cs,
    output logic                          reg_we,
    output logic [ADDR_W-1:0]             reg_addr,
    output logic [DATA_W-1:0]             reg_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] reg_rdata,
    output logic                          err_sticky,
    output logic [ADDR_W-1:0]             err_addr,
    input  logic                          err_clr
);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    logic [NUM_REGIONS-1:0] reg_cs_q, reg_cs_d;
    logic                   reg_we_q, reg_we_d;
    logic [ADDR_W-1:0]      reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]      reg_wdata_q, reg_wdata_d;
    logic [DATA_W-1:0]      avs_readdata_q, avs_readdata_d;
    logic                   avs_readdatavalid_q, avs_readdatavalid_d;
    logic [PEND_W-1:0]      pending_q, pending_d;
    logic                   err_sticky_q, err_sticky_d;
    logic [ADDR_W-1:0]      err_addr_q, err_addr_d;

    logic                   hit;
    region_idx_t            hit_idx;
    logic [ADDR_W-1:0]      hit_base;
    logic                   accept, rd_acc, fwd, err;
    logic [DATA_W-1:0]      rd_sel;
    read_tag_t              tag_in, tag_out;

    // descending scan so the lowest matching index is the one left standing
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        hit_base = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if (region_hit(ADDR_MAX_W'(avs_address),
                           ADDR_MAX_W'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                           ADDR_MAX_W'(REGION_LIMIT[i*ADDR_W +: ADDR_W]))) begin
                hit = 1'b1;
                hit_idx = region_idx_t'(i);
                hit_base = REGION_BASE[i*ADDR_W +: ADDR_W];
            end
    end

    assign avs_waitrequest = avs_read & (pending_q == PEND_W'(MAX_PENDING));
    assign accept = avs_chipselect & (avs_read | avs_write) & ~avs_waitrequest;
    assign rd_acc = accept & avs_read & ~avs_write;
    assign fwd    = accept & hit;
    assign err    = accept & (~hit | (avs_read & avs_write));
    assign tag_in = '{valid: rd_acc, idx: hit_idx, unmapped: ~hit};

    read_tag_pipe #(.DEPTH(RD_LATENCY + 1)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (tag_out.idx == region_idx_t'(i)) rd_sel = reg_rdata[i*DATA_W +: DATA_W];
    end

    always_comb begin
        reg_cs_d            = fwd ? NUM_REGIONS'(1) << hit_idx : '0;
        reg_we_d            = fwd & avs_write;
        reg_addr_d          = fwd ? avs_address - hit_base : '0;
        reg_wdata_d         = fwd ? avs_writedata : '0;
        avs_readdatavalid_d = tag_out.valid;
        avs_readdata_d      = !tag_out.valid ? '0 : tag_out.unmapped ? DEFAULT_RDATA : rd_sel;
        pending_d           = pending_q + PEND_W'(rd_acc) - PEND_W'(avs_readdatavalid_q);
        err_sticky_d        = err | (err_sticky_q & ~err_clr);
        err_addr_d          = err ? ((~err_sticky_q | err_clr) ? avs_address : err_addr_q)
                                  : (err_clr ? '0 : err_addr_q);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            reg_cs_q            <= '0;
            reg_we_q            <= 1'b0;
            reg_addr_q          <= '0;
            reg_wdata_q         <= '0;
            avs_readdata_q      <= '0;
            avs_readdatavalid_q <= 1'b0;
            pending_q           <= '0;
            err_sticky_q        <= 1'b0;
            err_addr_q          <= '0;
        end else begin
            reg_cs_q            <= reg_cs_d;
            reg_we_q            <= reg_we_d;
            reg_addr_q          <= reg_addr_d;
            reg_wdata_q         <= reg_wdata_d;
            avs_readdata_q      <= avs_readdata_d;
            avs_readdatavalid_q <= avs_readdatavalid_d;
            pending_q           <= pending_d;
            err_sticky_q        <= err_sticky_d;
            err_addr_q          <= err_addr_d;
        end

    assign reg_cs            = reg_cs_q;
    assign reg_we            = reg_we_q;
    assign reg_addr          = reg_addr_q;
    assign reg_wdata         = reg_wdata_q;
    assign avs_readdata      = avs_readdata_q;
    assign avs_readdatavalid = avs_readdatavalid_q;
    assign err_sticky        = err_sticky_q;
    assign err_addr          = err_addr_q;
endmodule

// File: tb/tb_region_decoder_pipelined.sv
// tb_region_decoder_pipelined: vector table, directed corners and randomized traffic against a queue-based model
module tb_region_decoder_pipelined;
    localparam int AW = 12, DW = 32, NR = 5, RL = 1, MP = 2;
    localparam logic [NR*AW-1:0] BASE  = {12'hE00, 12'hC00, 12'h800, 12'h400, 12'h000};
    localparam logic [NR*AW-1:0] LIMIT = {12'hFFF, 12'hCFF, 12'hBFF, 12'h7FF, 12'h7FF};
    localparam logic [DW-1:0] DEF = 32'hDEAD_BEEF;

    int mb[NR] = '{'h000, 'h400, 'h800, 'hC00, 'hE00};
    int ml[NR] = '{'h7FF, 'h7FF, 'hBFF, 'hCFF, 'hFFF};

    logic clk = 0, reset_n = 0;
    logic [AW-1:0] avs_address = '0;
    logic avs_chipselect = 0, avs_read = 0, avs_write = 0, err_clr = 0;
    logic [DW-1:0] avs_writedata = '0, avs_readdata, reg_wdata;
    logic avs_readdatavalid, avs_waitrequest, reg_we, err_sticky;
    logic [NR-1:0] reg_cs;
    logic [AW-1:0] reg_addr, err_addr;
    logic [NR*DW-1:0] reg_rdata = '0;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    region_decoder_pipelined #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(NR), .REGION_BASE(BASE), .REGION_LIMIT(LIMIT),
        .RD_LATENCY(RL), .MAX_PENDING(MP), .DEFAULT_RDATA(DEF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_chipselect(avs_chipselect),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .avs_waitrequest(avs_waitrequest), .reg_cs(reg_cs), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .err_sticky(err_sticky), .err_addr(err_addr),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] ram_word(int r, int off);
        return {8'hA5, 4'(r), 4'h5, 4'h0, 12'(off)};
    endfunction

    function automatic int region_of(int a);
        for (int r = 0; r < NR; r++) if (a >= mb[r] && a <= ml[r]) return r;
        return -1;
    endfunction

    // one-cycle-latency region RAMs; unselected lanes carry junk so a wrong lane pick shows up
    always @(posedge clk)
        for (int r = 0; r < NR; r++)
            reg_rdata[r*DW +: DW] <= reg_cs[r] ? ram_word(r, int'(reg_addr)) : {28'hBAD0000, 4'(r)};

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [31:0] data; int due; } rd_t;
    rd_t rq[$];
    logic [NR+1+AW+DW-1:0] exp_s1 = '0;
    logic m_sticky = 0;
    logic [AW-1:0] m_eaddr = '0;

    always @(negedge clk) begin : mon
        int r, pend;
        logic acc, mw, ev;
        rd_t e;
        if (!reset_n) begin
            rq.delete();
            exp_s1 = '0;
            m_sticky = 0;
            m_eaddr = '0;
        end
        pend = rq.size();
        mw = avs_read && (pend == MP);
        ev = 0;
        if (pend > 0) ev = (rq[0].due == cyc);
        chk("stage1", {reg_cs, reg_we, reg_addr, reg_wdata}, exp_s1);
        chk("rdvalid", avs_readdatavalid, ev);
        chk("waitreq", avs_waitrequest, mw);
        chk("err", {err_sticky, err_addr}, {m_sticky, m_eaddr});
        if (avs_readdatavalid && pend > 0) begin
            chk("rdata", avs_readdata, rq[0].data);
            void'(rq.pop_front());
        end
        exp_s1 = '0;
        if (reset_n) begin
            acc = avs_chipselect && (avs_read || avs_write) && !mw;
            r = region_of(int'(avs_address));
            if (acc && r >= 0)
                exp_s1 = {NR'(1) << r, avs_write, AW'(int'(avs_address) - mb[r]), avs_writedata};
            if (acc && avs_read && !avs_write) begin
                e.data = (r < 0) ? DEF : ram_word(r, int'(avs_address) - mb[r]);
                e.due = cyc + RL + 2;
                rq.push_back(e);
            end
            if (acc && (r < 0 || (avs_read && avs_write))) begin
                if (!m_sticky || err_clr) m_eaddr = avs_address;
                m_sticky = 1;
            end else if (err_clr) begin
                m_sticky = 0;
                m_eaddr = '0;
            end
        end
    end

    task automatic drive(logic cs, logic rd, logic wr, logic [AW-1:0] a, logic [DW-1:0] d, logic clr);
        @(posedge clk);
        #1;
        avs_chipselect = cs;
        avs_read = rd;
        avs_write = wr;
        avs_address = a;
        avs_writedata = d;
        err_clr = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0, 0);
    endtask

    task automatic wait_rdv(output int k);
        k = 0;
        while (!avs_readdatavalid && k < 8) begin
            @(negedge clk);
            k++;
        end
    endtask

    typedef struct {
        logic rd, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NR-1:0] cs;
        logic [AW-1:0] off;
        logic [DW-1:0] rdata;
    } vec_t;
    vec_t vt[10];

    initial begin #200000; $display("FAIL watchdog: got timeout expected finish"); $fatal(1); end

    initial begin
        int k;
        int waited[6];
        vt[0] = '{0, 1, 12'h405, 32'h1234_5678, 5'b00001, 12'h405, 32'h0};
        vt[1] = '{1, 0, 12'h500, 32'h0,         5'b00001, 12'h500, 32'hA505_0500};
        vt[2] = '{0, 1, 12'h9AB, 32'hCAFE_F00D, 5'b00100, 12'h1AB, 32'h0};
        vt[3] = '{1, 0, 12'hE07, 32'h0,         5'b10000, 12'h007, 32'hA545_0007};
        vt[4] = '{1, 0, 12'hC3F, 32'h0,         5'b01000, 12'h03F, 32'hA535_003F};
        vt[5] = '{0, 1, 12'hFFF, 32'h0000_0001, 5'b10000, 12'h1FF, 32'h0};
        vt[6] = '{1, 0, 12'h000, 32'h0,         5'b00001, 12'h000, 32'hA505_0000};
        vt[7] = '{1, 0, 12'hBFF, 32'h0,         5'b00100, 12'h3FF, 32'hA525_03FF};
        vt[8] = '{1, 0, 12'h7FF, 32'h0,         5'b00001, 12'h7FF, 32'hA505_07FF};
        vt[9] = '{1, 0, 12'h400, 32'h0,         5'b00001, 12'h400, 32'hA505_0400};

        @(negedge clk);
        chk("reset_outputs", {avs_readdata, avs_readdatavalid, avs_waitrequest, reg_cs, reg_we,
                              reg_addr, reg_wdata, err_sticky, err_addr}, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        for (int i = 0; i < 10; i++) begin
            drive(1, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, 0);
            idle();
            @(negedge clk);
            chk("tbl_stage1", {reg_cs, reg_we, reg_addr, reg_wdata}, {vt[i].cs, vt[i].wr, vt[i].off, vt[i].d});
            idle();
            @(negedge clk);
            chk("tbl_idle", {reg_cs, reg_we, reg_addr, reg_wdata}, '0);
            if (vt[i].rd) begin
                wait_rdv(k);
                chk("tbl_latency", k, 1);
                chk("tbl_rdata", avs_readdata, vt[i].rdata);
            end
        end

        drive(1, 0, 1, 12'hD00, 32'h1111, 0);
        idle();
        @(negedge clk);
        chk("hole_cs", reg_cs, '0);
        chk("hole_err", {err_sticky, err_addr}, {1'b1, 12'hD00});
        drive(1, 0, 1, 12'hD10, 32'h2222, 0);
        idle();
        @(negedge clk);
        chk("hole_err_first", {err_sticky, err_addr}, {1'b1, 12'hD00});
        drive(0, 0, 0, '0, '0, 1);
        idle();
        @(negedge clk);
        chk("hole_err_clr", {err_sticky, err_addr}, '0);
        drive(1, 1, 0, 12'hD00, '0, 0);
        idle();
        @(negedge clk);
        wait_rdv(k);
        chk("hole_rdv", avs_readdatavalid, 1);
        chk("hole_rdata", avs_readdata, DEF);
        drive(1, 0, 1, 12'hD20, '0, 1);
        idle();
        @(negedge clk);
        chk("clr_vs_err", {err_sticky, err_addr}, {1'b1, 12'hD20});
        drive(0, 0, 0, '0, '0, 1);
        drive(1, 1, 1, 12'h800, 32'h55, 0);
        idle();
        @(negedge clk);
        chk("rdwr_stage1", {reg_cs, reg_we, reg_addr, reg_wdata}, {5'b00100, 1'b1, 12'h000, 32'h55});
        chk("rdwr_err", {err_sticky, err_addr}, {1'b1, 12'h800});
        repeat (4) idle();
        drive(0, 0, 0, '0, '0, 1);

        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 12'h800 + 12'(i), '0, 0);
            waited[i] = 0;
            @(negedge clk);
            while (avs_waitrequest && waited[i] < 20) begin
                @(negedge clk);
                waited[i]++;
            end
        end
        idle();
        chk("b2b_no_stall_12", waited[0] + waited[1], 0);
        chk("b2b_stall_3rd", waited[2], 2);
        repeat (8) idle();

        drive(1, 0, 1, 12'hD40, '0, 0);
        drive(1, 1, 0, 12'h801, '0, 0);
        drive(1, 1, 0, 12'h802, '0, 0);
        @(posedge clk);
        #1;
        reset_n = 0;
        avs_chipselect = 0;
        avs_read = 0;
        avs_write = 0;
        @(negedge clk);
        chk("midrst_outputs", {avs_readdata, avs_readdatavalid, avs_waitrequest, reg_cs, reg_we,
                               reg_addr, reg_wdata, err_sticky, err_addr}, '0);
        @(posedge clk);
        #1 reset_n = 1;
        k = 0;
        repeat (6) begin
            @(negedge clk);
            k += int'(avs_readdatavalid);
        end
        chk("midrst_no_rdv", k, 0);
        drive(1, 1, 0, 12'h803, '0, 0);
        @(negedge clk);
        chk("midrst_pending", avs_waitrequest, 0);
        repeat (8) idle();

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? 12'hD00 | 12'($urandom_range(0, 255)) : 12'($urandom);
            drive($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 9) == 0);
        end
        repeat (10) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
